// File: rtl/v_display_pkg.sv
// Shared definitions for the virtual display transmitters.
// Contents:
//   state_e       - transmitter FSM encoding (Idle/Scan/Present/Finish).
//   ChunkType*    - chunk-type codes understood by the UART chunk mux.
//   group_count() - number of payload groups in a display buffer.
package v_display_pkg;

  typedef enum logic [1:0] {
    StIdle    = 2'd0,
    StScan    = 2'd1,
    StPresent = 2'd2,
    StFinish  = 2'd3
  } state_e;

  localparam logic [7:0] ChunkTypeDisplay = 8'd6;
  localparam logic [7:0] ChunkTypeLeds    = 8'd7;

  function automatic int unsigned group_count(input int unsigned byte_size,
                                              input int unsigned payload_bytes);
    return byte_size / payload_bytes;
  endfunction

endpackage

// File: rtl/v_display_group_cmp.sv
// Combinational group selector/comparator.
// Picks group group_i (PayloadBytes contiguous bytes) out of a snapshot image and a
// reference image, returns the snapshot payload and whether the two differ.
// Ports:
//   snapshot_i - image being transmitted
//   sent_i     - image last acknowledged by the consumer
//   group_i    - group number to inspect
//   differ_o   - snapshot group != reference group
//   payload_o  - snapshot group contents, byte j at payload_o[8j+:8]
module v_display_group_cmp #(
  parameter int unsigned ByteSize     = 64,
  parameter int unsigned PayloadBytes = 1,
  parameter int unsigned IdxW         = 8
) (
  input  logic [ByteSize*8-1:0]     snapshot_i,
  input  logic [ByteSize*8-1:0]     sent_i,
  input  logic [IdxW-1:0]           group_i,
  output logic                      differ_o,
  output logic [PayloadBytes*8-1:0] payload_o
);
  import v_display_pkg::*;

  localparam int unsigned GrpW   = PayloadBytes * 8;
  localparam int unsigned Groups = group_count(ByteSize, PayloadBytes);

  logic [GrpW-1:0] sent_grp;

  // Explicit mux over constant slices keeps index widths exact.
  always_comb begin
    payload_o = '0;
    sent_grp  = '0;
    for (int unsigned k = 0; k < Groups; k++) begin
      if (group_i == IdxW'(k)) begin
        payload_o = snapshot_i[k*GrpW +: GrpW];
        sent_grp  = sent_i[k*GrpW +: GrpW];
      end
    end
    differ_o = (payload_o != sent_grp);
  end

endmodule

// File: rtl/v_display_diff.sv
// Differential virtual display transmitter.
// Snapshots the display, compares it group by group against the image last sent, and
// presents only changed groups as chunks over a valid/ack handshake.
// Optional feature macro: V_DISPLAY_FULL_REFRESH_EN (adds force_refresh, which makes
// the next frame send every group).
// Ports:
//   CLK, RST_N      - clock, asynchronous active-low reset
//   display         - live image, byte k at display[8k+:8]
//   should_update   - chunk valid (registered)
//   tx_chunk_type   - constant INTERFACE_TX_CHUNK_TYPE
//   tx_chunk_bytes  - [7:0] start byte index, byte j+1 = display byte index+j
//   updated         - consumer ack
//   busy            - frame in progress
//   force_refresh   - (feature only) request a full resend
module v_display_diff #(
  parameter int unsigned INTERFACE_TX_CHUNK_TYPE   = 6,
  parameter int unsigned DISPLAY_BUFFER_BYTE_SIZE  = 64,
  parameter int unsigned DISPLAY_BUFFER_INDEX_SIZE = 8,
  parameter int unsigned PAYLOAD_BYTES             = 1
) (
  input  logic                                  CLK,
  input  logic                                  RST_N,
  input  logic [DISPLAY_BUFFER_BYTE_SIZE*8-1:0] display,
`ifdef V_DISPLAY_FULL_REFRESH_EN
  input  logic                                  force_refresh,
`endif
  output logic                                  should_update,
  output logic [7:0]                            tx_chunk_type,
  output logic [8*(PAYLOAD_BYTES+1)-1:0]        tx_chunk_bytes,
  input  logic                                  updated,
  output logic                                  busy
);
  import v_display_pkg::*;

  localparam int unsigned DispW  = DISPLAY_BUFFER_BYTE_SIZE * 8;
  localparam int unsigned GrpW   = PAYLOAD_BYTES * 8;
  localparam int unsigned ChunkW = 8 * (PAYLOAD_BYTES + 1);
  localparam int unsigned IdxW   = DISPLAY_BUFFER_INDEX_SIZE;
  localparam int unsigned Groups = group_count(DISPLAY_BUFFER_BYTE_SIZE, PAYLOAD_BYTES);
  localparam logic [IdxW-1:0] LastGroup = IdxW'(Groups - 1);

  state_e              state_q, state_d;
  logic [DispW-1:0]    snapshot_q, snapshot_d;
  logic [DispW-1:0]    sent_q, sent_d;
  logic [IdxW-1:0]     group_q, group_d;
  logic [ChunkW-1:0]   chunk_q, chunk_d;
  logic                should_update_q, should_update_d;
  logic                busy_q, busy_d;

  logic                grp_differ;
  logic [GrpW-1:0]     grp_payload;
  logic [7:0]          start_idx;
  logic                sent_wr;
  logic                enter_scan;
  logic                refresh_pending;
  logic                full_frame;

  v_display_group_cmp #(
    .ByteSize     (DISPLAY_BUFFER_BYTE_SIZE),
    .PayloadBytes (PAYLOAD_BYTES),
    .IdxW         (IdxW)
  ) u_group_cmp (
    .snapshot_i (snapshot_q),
    .sent_i     (sent_q),
    .group_i    (group_q),
    .differ_o   (grp_differ),
    .payload_o  (grp_payload)
  );

  assign start_idx = 8'(32'(group_q) * PAYLOAD_BYTES);

`ifdef V_DISPLAY_FULL_REFRESH_EN
  logic refresh_req_q, refresh_req_d;
  logic full_frame_q, full_frame_d;

  // Request is sticky; a pulse coinciding with frame start survives for the next frame.
  always_comb begin
    refresh_req_d = (refresh_req_q & ~enter_scan) | force_refresh;
    full_frame_d  = enter_scan ? refresh_req_q : full_frame_q;
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      refresh_req_q <= 1'b0;
      full_frame_q  <= 1'b0;
    end else begin
      refresh_req_q <= refresh_req_d;
      full_frame_q  <= full_frame_d;
    end
  end

  assign refresh_pending = refresh_req_q;
  assign full_frame      = full_frame_q;
`else
  assign refresh_pending = 1'b0;
  assign full_frame      = 1'b0;
`endif

  always_comb begin
    state_d    = state_q;
    snapshot_d = snapshot_q;
    group_d    = group_q;
    chunk_d    = chunk_q;
    sent_wr    = 1'b0;
    enter_scan = 1'b0;

    unique case (state_q)
      StIdle: begin
        if ((display != sent_q) || refresh_pending) begin
          snapshot_d = display;
          group_d    = '0;
          enter_scan = 1'b1;
          state_d    = StScan;
        end
      end
      StScan: begin
        if (grp_differ || full_frame) begin
          chunk_d = {grp_payload, start_idx};
          state_d = StPresent;
        end else if (group_q == LastGroup) begin
          state_d = StFinish;
        end else begin
          group_d = group_q + IdxW'(1);
        end
      end
      StPresent: begin
        if (updated) begin
          sent_wr = 1'b1;
          if (group_q == LastGroup) begin
            state_d = StFinish;
          end else begin
            group_d = group_q + IdxW'(1);
            state_d = StScan;
          end
        end
      end
      StFinish: state_d = StIdle;
      default:  state_d = StIdle;
    endcase

    // Outputs are decoded from the next state so they come straight from flops.
    should_update_d = (state_d == StPresent);
    busy_d          = (state_d != StIdle);
  end

  // Commit the acknowledged group into the reference image.
  always_comb begin
    sent_d = sent_q;
    for (int unsigned k = 0; k < Groups; k++) begin
      if (sent_wr && (group_q == IdxW'(k))) begin
        sent_d[k*GrpW +: GrpW] = grp_payload;
      end
    end
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_q         <= StIdle;
      snapshot_q      <= '0;
      sent_q          <= '0;
      group_q         <= '0;
      chunk_q         <= '0;
      should_update_q <= 1'b0;
      busy_q          <= 1'b0;
    end else begin
      state_q         <= state_d;
      snapshot_q      <= snapshot_d;
      sent_q          <= sent_d;
      group_q         <= group_d;
      chunk_q         <= chunk_d;
      should_update_q <= should_update_d;
      busy_q          <= busy_d;
    end
  end

  assign should_update  = should_update_q;
  assign busy           = busy_q;
  assign tx_chunk_bytes = chunk_q;
  assign tx_chunk_type  = 8'(INTERFACE_TX_CHUNK_TYPE);

endmodule

// File: doc/v_display_diff.md
Name: v_display_diff

Overview:
- Parametrised successor to the virtual display transmitter.
- Snapshots the display buffer and compares it against the last image actually transmitted.
- Emits only the changed pixel groups as TX chunks over a valid/ack handshake to the UART chunk mux.
- Each group carries PAYLOAD_BYTES contiguous bytes plus a one-byte start index. Unchanged groups cost one scan cycle and no UART traffic.

Parameters:
- INTERFACE_TX_CHUNK_TYPE, 6: value driven on tx_chunk_type.
- DISPLAY_BUFFER_BYTE_SIZE, 64: display size in bytes; must be a multiple of PAYLOAD_BYTES and ≤256.
- DISPLAY_BUFFER_INDEX_SIZE, 8: width of the internal byte index; ≤8.
- PAYLOAD_BYTES, 1: display bytes per chunk; legal values 1, 2, 4, 8.

Ports:
- CLK  in  1  system clock, all logic on posedge.
- RST_N  in  1  asynchronous active-low reset.
- display  in  DISPLAY_BUFFER_BYTE_SIZE*8  live display image; byte k is display[8k+:8].
- should_update  out  1  chunk valid; tx_chunk_bytes is stable while high.
- tx_chunk_type  out  8  constant INTERFACE_TX_CHUNK_TYPE.
- tx_chunk_bytes  out  8*(PAYLOAD_BYTES+1)  [7:0] = start byte index; byte j+1 = display byte (index+j).
- updated  in  1  ack from the consumer; chunk consumed when should_update && updated.
- busy  out  1  high in every state except IDLE.

Behaviour:
- Reset (RST_N low, asynchronous):
  - state = IDLE; snapshot = 0; sent-image = 0; group index = 0; chunk register = 0.
  - Outputs: should_update = 0, busy = 0, tx_chunk_bytes = 0. tx_chunk_type is constant.
  - Reset asserted mid-frame aborts the frame; no partial-chunk state survives.
- Number of groups: G = DISPLAY_BUFFER_BYTE_SIZE / PAYLOAD_BYTES. Group g covers bytes g*PAYLOAD_BYTES to g*PAYLOAD_BYTES + PAYLOAD_BYTES - 1.
- IDLE:
  - If display != sent-image: latch display into snapshot, set g = 0, go to SCAN.
  - Otherwise stay in IDLE.
- SCAN (one group per cycle):
  - If snapshot group g != sent-image group g: load the chunk register with {snapshot group g, start byte index}, go to PRESENT.
  - Else if g == G-1: go to FINISH.
  - Else: g += 1, stay in SCAN.
- PRESENT:
  - should_update = 1 (registered decode of state); the chunk register is held.
  - On updated: write snapshot group g into sent-image group g. Then go to FINISH if g == G-1; otherwise g += 1 and go to SCAN.
  - updated arriving while should_update is low is ignored.
- FINISH: one cycle, then IDLE. IDLE re-compares the live display, so changes made during a frame are picked up by the next frame.
- Snapshot is frozen for the whole frame; display activity mid-frame never alters a chunk in flight.
- Latency:
  - First chunk valid 2 cycles after the first changed display edge, if group 0 changed.
  - Each unchanged group adds 1 cycle.
  - Ack to next valid is ≥2 cycles.
- Boundaries:
  - The index byte is the start byte index, zero-extended to 8 bits.
  - The last group never wraps g.
  - A frame where the display changes and then reverts before IDLE samples it sends nothing.

Optional Feature:
- Macro: V_DISPLAY_FULL_REFRESH_EN.
- Defined:
  - Adds input force_refresh (1 bit).
  - A pulse latches a sticky refresh request. In IDLE the request starts a frame even when display == sent-image.
  - During that frame SCAN treats every group as changed, so all G groups are emitted. The request clears on entry to SCAN.
  - A pulse mid-frame is held for the next frame.
- Undefined: no port, no logic; only changed groups are ever sent.

Decomposition:
- Shared package v_display_pkg:
  - State encoding: IDLE=0, SCAN=1, PRESENT=2, FINISH=3, 2-bit.
  - Chunk-type constants: DISPLAY=6, LEDS.
  - Helper function returning the group count.
- Sub-module v_display_group_cmp:
  - Combinational: selects group g from snapshot and sent-image.
  - Outputs the differ flag and the group payload.
  - Reused by the future sprite and text-layer transmitters.

Test Plan:
- Reset then display = 0 for 100 cycles -> should_update never asserts, busy = 0.
- Defaults, display byte 5 = 0xA7, immediate ack -> exactly one chunk 0xA705, then busy drops; no further chunks.
- PAYLOAD_BYTES=4, bytes 0 and 63 changed to 0x11 / 0x22 -> chunks {0,0,0,0x11,idx 0x00} and {0x22,0,0,0,idx 0x3C}, in order; nothing else.
- Ack held low 50 cycles during PRESENT, display changed meanwhile -> tx_chunk_bytes stable; the new change is sent in a second frame after FINISH.
- RST_N pulsed low mid-PRESENT -> should_update drops the same cycle (async); after release, a still-differing display is fully resent.
- With V_DISPLAY_FULL_REFRESH_EN, force_refresh pulse with unchanged display -> exactly 64 chunks, indices 0x00..0x3F, ascending.
